// File: rtl/pipe_io_pkg.sv
// Shared definitions for the MEM-stage IO sequencer.
// Holds the state encoding, the default IO decode constants and the helper
// that sizes the watchdog counter from the timeout length.
package pipe_io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } io_state_t;

    localparam logic [31:0] IO_MASK_DEFAULT  = 32'hFFFF_FF80;
    localparam logic [31:0] IO_MATCH_DEFAULT = 32'h0000_0080;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_0000;

    // Counter must hold values 0 .. timeout-1.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/pipe_io_wdt.sv
// Watchdog counter for IO accesses.
// Ports:
//   clock  - system clock, rising edge
//   resetn - synchronous active-low reset (count -> 0)
//   clr    - synchronous clear (count -> 0), wins over en
//   en     - advance the count by one
//   tc     - terminal count, high while count == TIMEOUT-1
module pipe_io_wdt
    import pipe_io_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = cnt_width(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (!resetn || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pipe_mem_io_ctrl.sv
// MEM-stage sequencer: RAM accesses pass straight through, accesses to the
// memory-mapped IO region run a req/ack handshake while the upstream pipeline
// is frozen and bubbles are written into MEM/WB.
// Ports:
//   clock, resetn               - clock and synchronous active-low reset
//   maddr, mdata                - MEM-stage address and store data
//   mwmem, mm2reg, mwreg        - MEM-stage store / load / reg-write
//   ram_rdata, ram_we           - RAM read data in, RAM write enable out
//   io_req, io_we, io_addr,
//   io_wdata, io_rdata, io_ack  - IO bus handshake
//   stall                       - freeze PC, IF/ID, ID/EX, EX/MEM
//   mwreg_o, mmo_o              - write enable and load data into MEM/WB
//   io_err                      - sticky timeout flag, cleared only by reset
module pipe_mem_io_ctrl
    import pipe_io_pkg::*;
#(
    parameter logic [31:0] IO_MASK  = IO_MASK_DEFAULT,
    parameter logic [31:0] IO_MATCH = IO_MATCH_DEFAULT,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] maddr,
    input  logic [31:0] mdata,
    input  logic        mwmem,
    input  logic        mm2reg,
    input  logic        mwreg,
    input  logic [31:0] ram_rdata,
    output logic        ram_we,
    output logic        io_req,
    output logic        io_we,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata,
    input  logic        io_ack,
    output logic        stall,
    output logic        mwreg_o,
    output logic [31:0] mmo_o,
    output logic        io_err
);

    io_state_t   state, state_next;
    logic [31:0] rbuf;
    logic        io_sel, io_op;
    logic        wdt_clr, wdt_en, wdt_tc;

    assign io_sel = ((maddr & IO_MASK) == IO_MATCH);
    assign io_op  = io_sel & (mwmem | mm2reg);

    pipe_io_wdt #(
        .TIMEOUT(TIMEOUT)
    ) u_wdt (
        .clock (clock),
        .resetn(resetn),
        .clr   (wdt_clr),
        .en    (wdt_en),
        .tc    (wdt_tc)
    );

    // An ack in the terminal-count cycle takes priority over the timeout.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state  <= IDLE;
            rbuf   <= '0;
            io_err <= 1'b0;
        end else begin
            state <= state_next;
            if (state == WAIT) begin
                if (io_ack) begin
                    rbuf <= io_rdata;
                end else if (wdt_tc) begin
                    rbuf   <= ERR_DATA;
                    io_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        io_req     = 1'b0;
        wdt_clr    = 1'b0;
        wdt_en     = 1'b0;
        case (state)
            IDLE: begin
                stall   = io_op;
                wdt_clr = 1'b1;
                if (io_op) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                stall  = 1'b1;
                io_req = 1'b1;
                if (io_ack || wdt_tc) begin
                    state_next = DONE;
                end else begin
                    wdt_en = 1'b1;
                end
            end
            DONE: begin
                wdt_clr    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // EX/MEM is frozen during WAIT, so the request fields can come straight
    // from the MEM-stage inputs.
    assign io_we    = io_req & mwmem;
    assign io_addr  = maddr;
    assign io_wdata = mdata;

    assign ram_we  = mwmem & ~io_sel;
    assign mwreg_o = mwreg & ~stall;
    assign mmo_o   = (state == DONE) ? rbuf : ram_rdata;

endmodule

// File: tb/tb_pipe_mem_io_ctrl.sv
// Self-checking bench for pipe_mem_io_ctrl: a vector table for single-cycle
// pass-through and decode behaviour, then hand-written IO handshake sequences.
module tb_pipe_mem_io_ctrl;

    localparam int TIMEOUT = 16;

    logic        clock;
    logic        resetn;
    logic [31:0] maddr, mdata, ram_rdata, io_addr, io_wdata, io_rdata, mmo_o;
    logic        mwmem, mm2reg, mwreg, ram_we, io_req, io_we, io_ack;
    logic        stall, mwreg_o, io_err;

    int totalChecks = 0;
    int badChecks   = 0;

    pipe_mem_io_ctrl #(
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .maddr    (maddr),
        .mdata    (mdata),
        .mwmem    (mwmem),
        .mm2reg   (mm2reg),
        .mwreg    (mwreg),
        .ram_rdata(ram_rdata),
        .ram_we   (ram_we),
        .io_req   (io_req),
        .io_we    (io_we),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .io_ack   (io_ack),
        .stall    (stall),
        .mwreg_o  (mwreg_o),
        .mmo_o    (mmo_o),
        .io_err   (io_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rstn;
        logic [31:0] addr;
        logic        wmem;
        logic        m2reg;
        logic        wreg;
        logic [31:0] rdata;
        logic        expStall;
        logic        expRamWe;
        logic        expMwreg;
        logic [31:0] expMmo;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        resetn    = v.rstn;
        maddr     = v.addr;
        mdata     = 32'h0;
        mwmem     = v.wmem;
        mm2reg    = v.m2reg;
        mwreg     = v.wreg;
        ram_rdata = v.rdata;
        io_ack    = 1'b0;
    endtask

    // Runs one IO access from its IDLE cycle through DONE, acting as the IO
    // slave. ackCycle is the 1-based WAIT cycle carrying io_ack, 0 = never.
    task automatic ioAccess(input logic [31:0] addr, input logic we,
                            input logic wreg, input logic [31:0] wdata,
                            input int ackCycle, input logic [31:0] rdata,
                            input logic [31:0] expMmo, input logic expErr);
        int  reqCycles   = 0;
        int  stallCycles = 0;
        int  bubbleBad   = 0;
        int  ramWeSeen   = 0;
        int  attrBad     = 0;
        int  expReq;
        bit  done        = 0;
        expReq = (ackCycle == 0) ? TIMEOUT : ackCycle;
        @(negedge clock);
        maddr     = addr;
        mdata     = wdata;
        mwmem     = we;
        mm2reg    = ~we;
        mwreg     = wreg;
        ram_rdata = 32'h7777_0000;
        io_rdata  = rdata;
        io_ack    = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) @(negedge clock);
            io_ack = io_req && (reqCycles + 1 == ackCycle);
            #1;
            if (stall) begin
                stallCycles++;
                if (mwreg_o) bubbleBad++;
            end
            if (io_req) begin
                reqCycles++;
                if (io_we !== we || io_addr !== addr || io_wdata !== wdata)
                    attrBad++;
            end
            if (ram_we) ramWeSeen++;
            if (!stall && c > 0) begin
                done = 1;
                checkOutput("done mmo_o", mmo_o, expMmo);
                checkOutput("done mwreg_o", {31'b0, mwreg_o}, {31'b0, wreg});
            end
        end
        io_ack = 1'b0;
        checkOutput("io sequence finished", {31'b0, done}, 32'd1);
        checkOutput("stall cycles", stallCycles, expReq + 1);
        checkOutput("io_req cycles", reqCycles, expReq);
        checkOutput("bubbles while stalled", bubbleBad, 0);
        checkOutput("ram_we on io addr", ramWeSeen, 0);
        checkOutput("io request fields", attrBad, 0);
        checkOutput("io_err", {31'b0, io_err}, {31'b0, expErr});
    endtask

    initial begin
        // {rstn, addr, wmem, m2reg, wreg, rdata, stall, ram_we, mwreg_o, mmo_o}
        vecs[0] = '{1'b1, 32'h0000_0040, 1'b0, 1'b1, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b1, 32'h0000_1234};
        vecs[1] = '{1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 32'h0000_AAAA, 1'b0, 1'b1, 1'b0, 32'h0000_AAAA};
        vecs[2] = '{1'b1, 32'h0000_0084, 1'b0, 1'b0, 1'b1, 32'h0000_0BAD, 1'b0, 1'b0, 1'b1, 32'h0000_0BAD};
        vecs[3] = '{1'b1, 32'h0000_007C, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 32'h0000_0001};
        vecs[4] = '{1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b1, 1'b0, 32'h0000_0002};
        vecs[5] = '{1'b1, 32'h8000_0080, 1'b1, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b1, 1'b0, 32'h0000_0003};
        vecs[6] = '{1'b0, 32'h0000_0080, 1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'h0000_0004};
        vecs[7] = '{1'b0, 32'h0000_00FF, 1'b1, 1'b0, 1'b0, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 32'h0000_0005};
        vecs[8] = '{1'b0, 32'h0000_00C0, 1'b1, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0, 1'b0, 32'h0000_0006};
        vecs[9] = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0007, 1'b0, 1'b0, 1'b1, 32'h0000_0007};

        resetn = 1'b0; maddr = 32'h0; mdata = 32'h0; mwmem = 1'b0; mm2reg = 1'b0;
        mwreg = 1'b1; ram_rdata = 32'h5A5A; io_rdata = 32'h0; io_ack = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checkOutput("reset io_req", {31'b0, io_req}, 32'd0);
        checkOutput("reset io_err", {31'b0, io_err}, 32'd0);
        checkOutput("reset stall", {31'b0, stall}, 32'd0);
        checkOutput("reset mmo_o", mmo_o, 32'h5A5A);
        checkOutput("reset mwreg_o", {31'b0, mwreg_o}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d stall", i), {31'b0, stall}, {31'b0, vecs[i].expStall});
            checkOutput($sformatf("vec%0d ram_we", i), {31'b0, ram_we}, {31'b0, vecs[i].expRamWe});
            checkOutput($sformatf("vec%0d mwreg_o", i), {31'b0, mwreg_o}, {31'b0, vecs[i].expMwreg});
            checkOutput($sformatf("vec%0d mmo_o", i), mmo_o, vecs[i].expMmo);
            checkOutput($sformatf("vec%0d io_req", i), {31'b0, io_req}, 32'd0);
        end
        resetn = 1'b1;

        ioAccess(32'h84, 1'b0, 1'b1, 32'h0, 1, 32'h0000_CAFE, 32'h0000_CAFE, 1'b0);
        ioAccess(32'hC0, 1'b1, 1'b0, 32'h55, 3, 32'h0000_0011, 32'h0000_0011, 1'b0);
        ioAccess(32'h88, 1'b0, 1'b1, 32'h0, TIMEOUT, 32'h0000_BEEF, 32'h0000_BEEF, 1'b0);
        ioAccess(32'h90, 1'b0, 1'b1, 32'h0, 1, 32'h0000_1111, 32'h0000_1111, 1'b0);
        ioAccess(32'h94, 1'b0, 1'b1, 32'h0, 1, 32'h0000_2222, 32'h0000_2222, 1'b0);
        ioAccess(32'h84, 1'b0, 1'b1, 32'h0, 0, 32'h0000_DEAD, 32'h0000_0000, 1'b1);
        ioAccess(32'hA0, 1'b0, 1'b1, 32'h0, 2, 32'h0000_3333, 32'h0000_3333, 1'b1);

        // Reset during the second WAIT cycle abandons the access.
        @(negedge clock);
        maddr = 32'h84; mwmem = 1'b0; mm2reg = 1'b1; mwreg = 1'b1;
        ram_rdata = 32'h0000_4444; io_ack = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        checkOutput("mid-wait io_req before edge", {31'b0, io_req}, 32'd1);
        @(negedge clock);
        #1;
        checkOutput("after reset io_req", {31'b0, io_req}, 32'd0);
        checkOutput("after reset io_err", {31'b0, io_err}, 32'd0);
        checkOutput("after reset stall", {31'b0, stall}, 32'd1);
        checkOutput("after reset mmo_o", mmo_o, 32'h0000_4444);
        checkOutput("after reset mwreg_o", {31'b0, mwreg_o}, 32'd0);
        @(negedge clock);
        resetn = 1'b1; maddr = 32'h40; io_ack = 1'b1; io_rdata = 32'h0000_9999;
        #1;
        checkOutput("spurious ack stall", {31'b0, stall}, 32'd0);
        checkOutput("spurious ack io_req", {31'b0, io_req}, 32'd0);
        @(negedge clock);
        io_ack = 1'b0;
        #1;
        checkOutput("post ack io_req", {31'b0, io_req}, 32'd0);
        checkOutput("post ack stall", {31'b0, stall}, 32'd0);
        checkOutput("post ack mmo_o", mmo_o, 32'h0000_4444);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
